sawtooth_counter_top: RTL and testbench
=======================================

Name: sawtooth_counter_top

Overview:
- Board-level top for a tick-driven sawtooth generator.
- A clock divider produces a slow tick (4 Hz on hardware); on each tick an FSM does one of three things: loads bounds N1 and N2 from switches, starts or pauses the ramp, or steps the ramp.
- Ramp value, period count and state are shown on LEDs and three 7-segment digits.
- Sits directly under the board pin wrapper.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 4, tick rate.
- DIV_HALF, CLK_HZ/(2*TICK_HZ), half-period of clc in clk_i cycles. Benches override it to a small value, e.g. 4.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-low reset
- v_i  in  1  "V" button: enter load mode / load data
- ST_i  in  1  start/pause button
- din_i  in  8  data switches (unsigned)
- Q_o  out  20  LEDs: [7:0]=dind, [15:8]=sawtooth_cntr, [18:16]=state, [19]=clc
- sseg0  out  7  hex digit of dind[3:0]
- sseg1  out  7  hex digit of dind[7:4]
- sseg3  out  7  hex digit of {1'b0,state}

Behaviour:
Clocking and reset:
- Single clock domain: clk_i.
- rst_i low asynchronously clears all registers.
- Reset values: clc=0, divider=0, state=IDLE, N1=N2=0, dind=0, sawtooth_cntr=0, Q_o=0.
- After reset, all three digits display "0".

Divider:
- Counter 0..DIV_HALF-1; clc toggles when it wraps, giving a 50% square wave.
- tick = single clk_i-cycle strobe asserted in the cycle clc goes 0->1.
- FSM registers update only on clk_i edges with tick=1. No derived clocks are used as clock pins.

Input sampling:
- v_i, ST_i and din_i are level-sampled at each tick.
- A button held for k ticks acts k times.
- If v_i and ST_i are both high, v_i wins.

States (3-bit encoding):
- IDLE=0
- WAIT_N1=1
- WAIT_N2=2
- READY=3
- RUN=4
- PAUSE=5
- Codes 6-7 go to IDLE on the next tick.

Transitions, evaluated per tick:
- IDLE: v -> WAIT_N1.
- WAIT_N1: v -> N1<=din_i, go WAIT_N2.
- WAIT_N2: v -> N2<=din_i, go READY.
- READY: ST -> dind<=lo, sawtooth_cntr<=0, go RUN.
- RUN, stepping: if dind==hi then dind<=lo and sawtooth_cntr<=sawtooth_cntr+1 (8-bit wrap), else dind<=dind+1. The first step occurs on the tick after entry.
- RUN, ST: go PAUSE, holding dind and cntr with no step on that tick.
- PAUSE: ST -> RUN, resuming from the held value.
- READY/RUN/PAUSE, v: go WAIT_N1 and clear dind and sawtooth_cntr. N1/N2 keep their old values until overwritten.
- Ramp bounds: lo=min(N1,N2), hi=max(N1,N2). If N1==N2, dind stays constant and cntr increments every tick.

Outputs:
- All outputs are registered or directly decoded, with no added latency beyond the register update.
- Segment order {g,f,e,d,c,b,a}, active-low. "0"=7'b1000000, "F"=7'b0001110.
- Hierarchy contract for benches: the top has signal clc and an FSM instance named fsm exposing state, N1_out, N2_out, sawtooth_cntr_out and dind_out.

Decomposition:
- Package sawtooth_pkg:
  - state_t enum with the six encodings above.
  - The Q_o bit-field offsets.
  - Function hex_to_sseg(4-bit) returning the 7-bit active-low pattern.
- One sub-module, sawtooth_fsm, instantiated as fsm.
  - Inputs: clk_i, rst_i, tick, v, st, din.
  - Outputs: state, N1_out, N2_out, sawtooth_cntr_out, dind_out.
- Divider and segment decode stay in the top.

Test Plan (DIV_HALF=4):
- Reset: hold rst_i low 5 clk cycles -> state=0, all counters 0, sseg0/1/3=7'b1000000, Q_o=0.
- Load: v 1 tick; then din=20 with v 1 tick; then din=40 with v 1 tick -> state 1, then 2 (N1=20), then 3 (N2=40).
- Run and wrap: ST 1 tick -> state=4, dind=20. After 21 more ticks dind has gone 21..40 and wrapped to 20 with sawtooth_cntr=1. After 50 ticks total, sawtooth_cntr=2.
- Pause/resume: ST in RUN -> state=5, dind frozen for 15 ticks. ST again -> state=4 and stepping continues from the held value.
- Reload reversed bounds: v in RUN -> state=1, dind=0, cntr=0. Load 76 then 15 (lo=15, hi=76). ST -> ramp 15..76, cntr increments every 62 ticks.
- Simultaneous v+ST in RUN -> state=1 (v priority). N1==N2=9 -> dind stays 9 and cntr increments every tick.

Source files
------------

// File: rtl/sawtooth_pkg.sv
// Shared types, LED field offsets and seven-segment decode for the sawtooth generator.
package sawtooth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_N1 = 3'd1,
        WAIT_N2 = 3'd2,
        READY   = 3'd3,
        RUN     = 3'd4,
        PAUSE   = 3'd5
    } state_t;

    localparam int Q_DIND_LSB  = 0;
    localparam int Q_CNTR_LSB  = 8;
    localparam int Q_STATE_LSB = 16;
    localparam int Q_CLC_BIT   = 19;

    // Active-low, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_sseg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sawtooth_counter_fsm.sv
// Tick-enabled control FSM: loads the two ramp bounds, then runs/pauses a sawtooth between them.
module sawtooth_fsm
    import sawtooth_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick,
    input  logic       v,
    input  logic       st,
    input  logic [7:0] din,
    output logic [2:0] state,
    output logic [7:0] N1_out,
    output logic [7:0] N2_out,
    output logic [7:0] sawtooth_cntr_out,
    output logic [7:0] dind_out
);

    logic [2:0] state_q, state_d;
    logic [7:0] n1_q, n1_d;
    logic [7:0] n2_q, n2_d;
    logic [7:0] dind_q, dind_d;
    logic [7:0] cntr_q, cntr_d;
    logic [7:0] lo, hi;

    // Bounds may be entered in either order.
    assign lo = (n1_q < n2_q) ? n1_q : n2_q;
    assign hi = (n1_q < n2_q) ? n2_q : n1_q;

    always_comb begin
        state_d = state_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        dind_d  = dind_q;
        cntr_d  = cntr_q;
        if (tick) begin
            case (state_q)
                IDLE: if (v) state_d = WAIT_N1;
                WAIT_N1: if (v) begin
                    n1_d    = din;
                    state_d = WAIT_N2;
                end
                WAIT_N2: if (v) begin
                    n2_d    = din;
                    state_d = READY;
                end
                READY, RUN, PAUSE: begin
                    if (v) begin
                        state_d = WAIT_N1;
                        dind_d  = 8'd0;
                        cntr_d  = 8'd0;
                    end else if (state_q == READY) begin
                        if (st) begin
                            dind_d  = lo;
                            cntr_d  = 8'd0;
                            state_d = RUN;
                        end
                    end else if (state_q == RUN) begin
                        if (st) begin
                            state_d = PAUSE;
                        end else if (dind_q == hi) begin
                            dind_d = lo;
                            cntr_d = cntr_q + 8'd1;
                        end else begin
                            dind_d = dind_q + 8'd1;
                        end
                    end else if (st) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            n1_q    <= 8'd0;
            n2_q    <= 8'd0;
            dind_q  <= 8'd0;
            cntr_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            dind_q  <= dind_d;
            cntr_q  <= cntr_d;
        end
    end

    assign state             = state_q;
    assign N1_out            = n1_q;
    assign N2_out            = n2_q;
    assign sawtooth_cntr_out = cntr_q;
    assign dind_out          = dind_q;

endmodule

// File: rtl/sawtooth_counter_top.sv
// Board top: tick divider, control FSM and LED / seven-segment output mapping.
module sawtooth_counter_top
    import sawtooth_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 4,
    parameter int DIV_HALF = CLK_HZ / (2 * TICK_HZ)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        v_i,
    input  logic        ST_i,
    input  logic [7:0]  din_i,
    output logic [19:0] Q_o,
    output logic [6:0]  sseg0,
    output logic [6:0]  sseg1,
    output logic [6:0]  sseg3
);

    localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    logic [DIV_W-1:0] div_q;
    logic             clc;
    logic             div_wrap;
    logic             tick;
    logic [2:0]       fsm_state;
    logic [7:0]       n1, n2, cntr, dind;

    assign div_wrap = (div_q == DIV_W'(DIV_HALF - 1));
    // The strobe coincides with the edge on which clc rises.
    assign tick     = div_wrap & ~clc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q <= '0;
            clc   <= 1'b0;
        end else if (div_wrap) begin
            div_q <= '0;
            clc   <= ~clc;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    sawtooth_fsm fsm (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .tick              (tick),
        .v                 (v_i),
        .st                (ST_i),
        .din               (din_i),
        .state             (fsm_state),
        .N1_out            (n1),
        .N2_out            (n2),
        .sawtooth_cntr_out (cntr),
        .dind_out          (dind)
    );

    always_comb begin
        Q_o = '0;
        Q_o[Q_DIND_LSB +: 8]  = dind;
        Q_o[Q_CNTR_LSB +: 8]  = cntr;
        Q_o[Q_STATE_LSB +: 3] = fsm_state;
        Q_o[Q_CLC_BIT]        = clc;
    end

    assign sseg0 = hex_to_sseg(dind[3:0]);
    assign sseg1 = hex_to_sseg(dind[7:4]);
    assign sseg3 = hex_to_sseg({1'b0, fsm_state});

endmodule

// File: tb/tb_sawtooth_counter_top.sv
// Randomised and directed bench for sawtooth_counter_top against a tick-level behavioural model.
module tb_sawtooth_counter_top;

    localparam int DIV_HALF = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        v_i   = 1'b0;
    logic        ST_i  = 1'b0;
    logic [7:0]  din_i = 8'd0;
    logic [19:0] Q_o;
    logic [6:0]  sseg0, sseg1, sseg3;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: ramp phase, stored bounds, displayed value and wrap count.
    int ms = 0;
    int m_n1 = 0, m_n2 = 0, m_dind = 0, m_cntr = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sawtooth_counter_top #(.DIV_HALF(DIV_HALF)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .v_i   (v_i),
        .ST_i  (ST_i),
        .din_i (din_i),
        .Q_o   (Q_o),
        .sseg0 (sseg0),
        .sseg1 (sseg1),
        .sseg3 (sseg3)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [19:0] exp_q();
        return {1'b1, 3'(ms), 8'(m_cntr), 8'(m_dind)};
    endfunction

    // Applies one tick of the specified behaviour to the model.
    task automatic model_tick(input logic v, input logic st, input int din);
        int lo, hi;
        lo = (m_n1 < m_n2) ? m_n1 : m_n2;
        hi = (m_n1 < m_n2) ? m_n2 : m_n1;
        if (ms == 0) begin
            if (v) ms = 1;
        end else if (ms == 1) begin
            if (v) begin m_n1 = din; ms = 2; end
        end else if (ms == 2) begin
            if (v) begin m_n2 = din; ms = 3; end
        end else if (v) begin
            ms = 1; m_dind = 0; m_cntr = 0;
        end else if (ms == 3) begin
            if (st) begin m_dind = lo; m_cntr = 0; ms = 4; end
        end else if (ms == 4) begin
            if (st) ms = 5;
            else if (m_dind - lo + 1 > hi - lo) begin
                m_dind = lo; m_cntr = (m_cntr + 1) % 256;
            end else m_dind = m_dind + 1;
        end else if (st) begin
            ms = 4;
        end
    endtask

    // Returns at the negedge following the next rising edge of clc (a tick edge).
    task automatic wait_tick(output int cyc);
        logic prev;
        prev = Q_o[19];
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            cyc++;
            if (!prev && Q_o[19]) return;
            prev = Q_o[19];
        end
        n_cmp++; n_bad++;
        $display("FAIL tick_timeout: no clc rise within %0d cycles", cyc);
    endtask

    task automatic step(input logic v, input logic st, input int din);
        int c;
        v_i = v; ST_i = st; din_i = 8'(din);
        wait_tick(c);
        model_tick(v, st, din);
        v_i = 1'b0; ST_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        n_cmp++;
        if (Q_o !== 20'd0) begin
            n_bad++; $display("FAIL reset_q: got %h want 0", Q_o);
        end
        n_cmp++;
        if (sseg0 !== 7'b1000000 || sseg1 !== 7'b1000000 || sseg3 !== 7'b1000000) begin
            n_bad++; $display("FAIL reset_sseg: got %b %b %b want 1000000 x3", sseg0, sseg1, sseg3);
        end
        n_cmp++;
        if (dut.fsm.N1_out !== 8'd0 || dut.fsm.N2_out !== 8'd0) begin
            n_bad++; $display("FAIL reset_bounds: got %0d %0d want 0 0", dut.fsm.N1_out, dut.fsm.N2_out);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_tick_period();
        int c;
        wait_tick(c);
        model_tick(1'b0, 1'b0, 0);
        wait_tick(c);
        model_tick(1'b0, 1'b0, 0);
        n_cmp++;
        if (c !== 2 * DIV_HALF) begin
            n_bad++; $display("FAIL tick_period: got %0d want %0d", c, 2 * DIV_HALF);
        end
        n_cmp++;
        if (Q_o !== exp_q()) begin
            n_bad++; $display("FAIL idle_q: got %h want %h", Q_o, exp_q());
        end
    endtask

    task automatic test_load();
        step(1'b1, 1'b0, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd1) begin
            n_bad++; $display("FAIL load_wait_n1: got %0d want 1", Q_o[18:16]);
        end
        step(1'b1, 1'b0, 20);
        n_cmp++;
        if (Q_o[18:16] !== 3'd2 || dut.fsm.N1_out !== 8'd20) begin
            n_bad++; $display("FAIL load_n1: got st=%0d n1=%0d want 2 20", Q_o[18:16], dut.fsm.N1_out);
        end
        step(1'b1, 1'b0, 40);
        n_cmp++;
        if (Q_o[18:16] !== 3'd3 || dut.fsm.N2_out !== 8'd40) begin
            n_bad++; $display("FAIL load_n2: got st=%0d n2=%0d want 3 40", Q_o[18:16], dut.fsm.N2_out);
        end
        n_cmp++;
        if (sseg3 !== seg_tab[3]) begin
            n_bad++; $display("FAIL sseg3_ready: got %b want %b", sseg3, seg_tab[3]);
        end
    endtask

    task automatic test_run_wrap();
        step(1'b0, 1'b1, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd4 || Q_o[7:0] !== 8'd20) begin
            n_bad++; $display("FAIL run_entry: got st=%0d dind=%0d want 4 20", Q_o[18:16], Q_o[7:0]);
        end
        for (int i = 1; i <= 50; i++) begin
            step(1'b0, 1'b0, 0);
            n_cmp++;
            if (Q_o !== exp_q() || sseg0 !== seg_tab[m_dind % 16] || sseg1 !== seg_tab[m_dind / 16]) begin
                n_bad++; $display("FAIL run_step%0d: got %h %b %b want %h", i, Q_o, sseg1, sseg0, exp_q());
            end
            if (i == 21) begin
                n_cmp++;
                if (Q_o[7:0] !== 8'd20 || Q_o[15:8] !== 8'd1) begin
                    n_bad++; $display("FAIL run_wrap1: got dind=%0d cntr=%0d want 20 1", Q_o[7:0], Q_o[15:8]);
                end
            end
        end
        n_cmp++;
        if (Q_o[15:8] !== 8'd2) begin
            n_bad++; $display("FAIL run_wrap2: got cntr=%0d want 2", Q_o[15:8]);
        end
    endtask

    task automatic test_pause();
        logic [7:0] held;
        held = Q_o[7:0];
        step(1'b0, 1'b1, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd5 || Q_o[7:0] !== held) begin
            n_bad++; $display("FAIL pause_entry: got st=%0d dind=%0d want 5 %0d", Q_o[18:16], Q_o[7:0], held);
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 0);
            n_cmp++;
            if (Q_o[7:0] !== held || Q_o !== exp_q()) begin
                n_bad++; $display("FAIL pause_hold%0d: got %h want %h", i, Q_o, exp_q());
            end
        end
        step(1'b0, 1'b1, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd4 || Q_o[7:0] !== held) begin
            n_bad++; $display("FAIL resume: got st=%0d dind=%0d want 4 %0d", Q_o[18:16], Q_o[7:0], held);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 0);
            n_cmp++;
            if (Q_o !== exp_q()) begin
                n_bad++; $display("FAIL resume_step%0d: got %h want %h", i, Q_o, exp_q());
            end
        end
    endtask

    task automatic test_reload();
        step(1'b1, 1'b0, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd1 || Q_o[15:0] !== 16'd0 || dut.fsm.N1_out !== 8'd20) begin
            n_bad++; $display("FAIL reload_clear: got %h n1=%0d want st1 zeros n1=20", Q_o, dut.fsm.N1_out);
        end
        step(1'b1, 1'b0, 76);
        step(1'b1, 1'b0, 15);
        step(1'b0, 1'b1, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd4 || Q_o[7:0] !== 8'd15) begin
            n_bad++; $display("FAIL reload_entry: got st=%0d dind=%0d want 4 15", Q_o[18:16], Q_o[7:0]);
        end
        for (int i = 1; i <= 124; i++) begin
            step(1'b0, 1'b0, 0);
            n_cmp++;
            if (Q_o !== exp_q()) begin
                n_bad++; $display("FAIL reload_step%0d: got %h want %h", i, Q_o, exp_q());
            end
            if (i == 61 || i == 62 || i == 124) begin
                n_cmp++;
                if (Q_o[15:8] !== 8'(i / 62) || Q_o[7:0] !== 8'(15 + (i % 62))) begin
                    n_bad++; $display("FAIL reload_wrap%0d: got cntr=%0d dind=%0d want %0d %0d",
                                      i, Q_o[15:8], Q_o[7:0], i / 62, 15 + (i % 62));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 0);
        n_cmp++;
        if (Q_o[18:16] !== 3'd1) begin
            n_bad++; $display("FAIL v_priority: got st=%0d want 1", Q_o[18:16]);
        end
        step(1'b1, 1'b0, 9);
        step(1'b1, 1'b0, 9);
        step(1'b0, 1'b1, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 0);
            n_cmp++;
            if (Q_o[7:0] !== 8'd9 || Q_o[15:8] !== 8'(i) || Q_o !== exp_q()) begin
                n_bad++; $display("FAIL equal_bounds%0d: got dind=%0d cntr=%0d want 9 %0d", i, Q_o[7:0], Q_o[15:8], i);
            end
        end
    endtask

    task automatic test_random();
        logic v, st;
        int din;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 5) == 0);
            din = ($urandom_range(0, 3) == 0) ? m_n1 : int'($urandom_range(0, 255));
            if (ms == 1 || ms == 2) din = int'($urandom_range(0, 12));
            step(v, st, din);
            n_cmp++;
            if (Q_o !== exp_q() || sseg0 !== seg_tab[m_dind % 16] || sseg1 !== seg_tab[m_dind / 16]
                || sseg3 !== seg_tab[ms] || dut.fsm.N1_out !== 8'(m_n1) || dut.fsm.N2_out !== 8'(m_n2)) begin
                n_bad++; $display("FAIL random%0d: got q=%h n1=%0d n2=%0d seg=%b/%b/%b want q=%h n1=%0d n2=%0d",
                                  i, Q_o, dut.fsm.N1_out, dut.fsm.N2_out, sseg3, sseg1, sseg0, exp_q(), m_n1, m_n2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_load();
        test_run_wrap();
        test_pause();
        test_reload();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
